// File: rtl/bf16_mac_sequencer.sv
// Job sequencer for the N-lane bf16 MAC array: streams len operand beats
// (first beat loads, the rest accumulate), waits out MAC latency, then holds the lane results.

module bf16_mac_sequencer_lane (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        beat,
    input  logic        cap,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] acc,
    output logic [15:0] op_a,
    output logic [15:0] op_b,
    output logic [15:0] res
);
    // Any cycle without an accepted beat drives zero operands, so the array adds +0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a <= '0;
            op_b <= '0;
            res  <= '0;
        end else begin
            op_a <= beat ? a : '0;
            op_b <= beat ? b : '0;
            if (cap) res <= acc;
        end
    end
endmodule

module bf16_mac_sequencer #(
    parameter int N       = 2,
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_W-1:0]      len,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0][15:0]    a_in,
    input  logic [N-1:0][15:0]    b_in,
    output logic [N-1:0][15:0]    mac_a,
    output logic [N-1:0][15:0]    mac_b,
    output logic                  mac_cntl,
    input  logic [N-1:0][15:0]    mac_out,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [N-1:0][15:0]    res_data
);
    localparam int DW = $clog2(MAC_LAT + 2);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, HOLD} state_t;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat_cnt;
    logic [LEN_W-1:0] beat_nxt;
    logic [DW-1:0]    drain_cnt;
    logic             accept;
    logic             cap;

    // in_ready is only ever high in FEED, so accept needs no state qualifier.
    assign accept   = in_valid && in_ready;
    assign cap      = (state == DRAIN) && (drain_cnt == '0);
    assign beat_nxt = beat_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            len_q     <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            res_valid <= 1'b0;
            mac_cntl  <= 1'b1;
        end else begin
            mac_cntl <= accept ? (beat_cnt != '0) : 1'b1;
            case (state)
                IDLE: if (start && len != '0) begin
                    len_q    <= len;
                    beat_cnt <= '0;
                    busy     <= 1'b1;
                    in_ready <= 1'b1;
                    state    <= FEED;
                end
                FEED: if (accept) begin
                    beat_cnt <= beat_nxt;
                    if (beat_nxt == len_q) begin
                        drain_cnt <= DW'(MAC_LAT);
                        in_ready  <= 1'b0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: if (drain_cnt == '0) begin
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end else begin
                    drain_cnt <= drain_cnt - 1'b1;
                end
                HOLD: if (res_ready) begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        bf16_mac_sequencer_lane u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .beat (accept),
            .cap  (cap),
            .a    (a_in[i]),
            .b    (b_in[i]),
            .acc  (mac_out[i]),
            .op_a (mac_a[i]),
            .op_b (mac_b[i]),
            .res  (res_data[i])
        );
    end
endmodule

// File: tb/tb_bf16_mac_sequencer.sv
// Bench for bf16_mac_sequencer with a behavioural bf16 MAC array model and result scoreboard.

module tb_bf16_mac_sequencer;
    localparam int N = 2, LEN_W = 8, MAC_LAT = 2;
    typedef logic [N-1:0][15:0] vec_t;

    logic             clk = 0, rst_n = 0, start = 0, in_valid = 0, res_ready = 0;
    logic [LEN_W-1:0] len = '0;
    vec_t             a_in = '0, b_in = '0;
    logic             busy, in_ready, mac_cntl, res_valid;
    vec_t             mac_a, mac_b, mac_out, res_data;

    int   total = 0, bad = 0;
    vec_t exp_q[$];

    bf16_mac_sequencer #(.N(N), .LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
        .mac_a(mac_a), .mac_b(mac_b), .mac_cntl(mac_cntl), .mac_out(mac_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    always #5 clk = ~clk;

    function automatic real bf2r(input logic [15:0] x);
        real r;
        int  e;
        if (x[14:0] == 15'd0) return 0.0;
        r = 1.0 + real'(x[6:0]) / 128.0;
        e = int'(x[14:7]) - 127;
        for (int k = 0; k < e; k++) r = r * 2.0;
        for (int k = 0; k < -e; k++) r = r / 2.0;
        return x[15] ? -r : r;
    endfunction

    function automatic logic [15:0] r2bf(input real v);
        real  r;
        int   e, m;
        logic s;
        if (v == 0.0) return 16'h0000;
        s = (v < 0.0);
        r = s ? -v : v;
        e = 127;
        for (int k = 0; k < 300 && r >= 2.0; k++) begin r = r / 2.0; e++; end
        for (int k = 0; k < 300 && r < 1.0; k++) begin r = r * 2.0; e--; end
        m = int'((r - 1.0) * 128.0);
        if (m > 127) begin m = 0; e++; end
        return {s, 8'(e), 7'(m)};
    endfunction

    // MAC array model: operands seen in cycle t appear on mac_out from cycle t+MAC_LAT.
    vec_t pipe [MAC_LAT];
    real  acc  [N];
    initial for (int k = 0; k < MAC_LAT; k++) pipe[k] = '0;
    always @(posedge clk) begin : mac_model
        vec_t nv;
        real  p;
        for (int i = 0; i < N; i++) begin
            p = bf2r(mac_a[i]) * bf2r(mac_b[i]);
            if (mac_cntl === 1'b0) acc[i] = p;
            else                   acc[i] = acc[i] + p;
            nv[i] = r2bf(acc[i]);
        end
        pipe[0] <= nv;
        for (int k = 1; k < MAC_LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mac_out = pipe[MAC_LAT-1];

    task automatic wait_res(input int lim, output bit ok);
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin ok = 1; return; end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (busy !== 0 || in_ready !== 0 || res_valid !== 0 || mac_cntl !== 1) begin
            bad++;
            $display("FAIL reset_ctrl: busy=%b in_ready=%b res_valid=%b mac_cntl=%b want 0 0 0 1",
                     busy, in_ready, res_valid, mac_cntl);
        end
        total++;
        if (mac_a !== '0 || mac_b !== '0 || res_data !== '0) begin
            bad++;
            $display("FAIL reset_data: mac_a=%h mac_b=%h res_data=%h want all 0", mac_a, mac_b, res_data);
        end
        rst_n = 1;
    endtask

    task automatic test_single();
        vec_t a, b, e;
        a = {16'h4000, 16'h3F80};
        b = {16'h3F80, 16'h4040};
        @(negedge clk);
        start = 1; len = 1; in_valid = 1; a_in = a; b_in = b; res_ready = 1;
        exp_q.push_back({16'h4000, 16'h4040});
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            start = 0;
            if (k == 1) begin
                total++;
                if (mac_cntl !== 0 || mac_a !== a || mac_b !== b) begin
                    bad++;
                    $display("FAIL single_beat: cntl=%b a=%h b=%h want cntl=0 a=%h b=%h", mac_cntl, mac_a, mac_b, a, b);
                end
                in_valid = 0;
            end
            total++;
            if (res_valid !== (k == 4)) begin
                bad++;
                $display("FAIL single_valid_edge%0d: res_valid=%b want %b", k, res_valid, (k == 4));
            end
            if (k == 4 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (res_data !== e) begin
                    bad++;
                    $display("FAIL single_data: res_data=%h want %h", res_data, e);
                end
            end
        end
    endtask

    task automatic test_toggle();
        vec_t one = {N{16'h3F80}};
        vec_t e;
        int   nacc = 0;
        bit   pv = 0, pr = 0, done = 0;
        @(negedge clk);
        start = 1; len = 4; a_in = one; b_in = one; in_valid = 0; res_ready = 1;
        exp_q.push_back({N{16'h4080}});
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            start = 0;
            total++;
            if (pv && pr) begin
                if (mac_a !== one || mac_b !== one || mac_cntl !== (nacc != 0)) begin
                    bad++;
                    $display("FAIL toggle_beat%0d: a=%h b=%h cntl=%b want %h %h %b", nacc, mac_a, mac_b, mac_cntl, one, one, (nacc != 0));
                end
                nacc++;
            end else if (mac_a !== '0 || mac_b !== '0 || mac_cntl !== 1) begin
                bad++;
                $display("FAIL toggle_bubble%0d: a=%h b=%h cntl=%b want 0 0 1", i, mac_a, mac_b, mac_cntl);
            end
            total++;
            if (in_ready !== (nacc < 4)) begin
                bad++;
                $display("FAIL toggle_in_ready%0d: in_ready=%b want %b", i, in_ready, (nacc < 4));
            end
            if (res_valid === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (res_data !== e || nacc != 4) begin
                    bad++;
                    $display("FAIL toggle_data: res_data=%h beats=%0d want %h beats=4", res_data, nacc, e);
                end
                done = 1;
            end
            in_valid = (i % 2 == 0);
            pv = in_valid;
            pr = in_ready;
        end
        total++;
        if (!done) begin bad++; $display("FAIL toggle_timeout: done=0 want 1"); end
        in_valid = 0;
        @(negedge clk);
        total++;
        if (res_valid !== 0 || busy !== 0) begin
            bad++;
            $display("FAIL toggle_idle: res_valid=%b busy=%b want 0 0", res_valid, busy);
        end
    endtask

    task automatic test_hold();
        vec_t one = {N{16'h3F80}};
        vec_t e = '0;
        bit   ok;
        int   hs = 0;
        @(negedge clk);
        start = 1; len = 1; a_in = one; b_in = one; in_valid = 1; res_ready = 0;
        exp_q.push_back(one);
        @(negedge clk);
        start = 0;
        wait_res(20, ok);
        in_valid = 0;
        total++;
        if (!ok) begin bad++; $display("FAIL hold_timeout: res_valid=0 want 1"); end
        if (exp_q.size() > 0) e = exp_q.pop_front();
        for (int i = 0; i < 6; i++) begin
            total++;
            if (res_valid !== 1 || res_data !== e || busy !== 1 || in_ready !== 0) begin
                bad++;
                $display("FAIL hold_stable%0d: valid=%b data=%h busy=%b in_ready=%b want 1 %h 1 0",
                         i, res_valid, res_data, busy, in_ready, e);
            end
            if (i == 5) break;
            start = 1; len = 3;
            @(negedge clk);
        end
        start = 0;
        res_ready = 1;
        for (int i = 0; i < 7; i++) begin
            if (res_valid === 1'b1 && res_ready) hs++;
            @(negedge clk);
            total++;
            if (res_valid !== 0 || busy !== 0) begin
                bad++;
                $display("FAIL hold_release%0d: res_valid=%b busy=%b want 0 0", i, res_valid, busy);
            end
        end
        total++;
        if (hs != 1) begin bad++; $display("FAIL hold_handshakes: count=%0d want 1", hs); end
    endtask

    task automatic test_zero_len();
        @(negedge clk);
        start = 1; len = 0; in_valid = 1; res_ready = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (busy !== 0 || in_ready !== 0 || res_valid !== 0) begin
                bad++;
                $display("FAIL zero_len%0d: busy=%b in_ready=%b res_valid=%b want 0 0 0", i, busy, in_ready, res_valid);
            end
            @(negedge clk);
        end
        in_valid = 0;
    endtask

    task automatic test_reset_mid();
        vec_t one = {N{16'h3F80}};
        vec_t two = {N{16'h4000}};
        vec_t e;
        @(negedge clk);
        start = 1; len = 4; a_in = one; b_in = one; in_valid = 1; res_ready = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1 || in_ready !== 1) begin
            bad++;
            $display("FAIL midjob_state: busy=%b in_ready=%b want 1 1", busy, in_ready);
        end
        rst_n = 0;
        #1;
        total++;
        if (busy !== 0 || in_ready !== 0 || res_valid !== 0 || mac_cntl !== 1 ||
            mac_a !== '0 || mac_b !== '0 || res_data !== '0) begin
            bad++;
            $display("FAIL midjob_reset: busy=%b rdy=%b vld=%b cntl=%b a=%h b=%h data=%h want 0 0 0 1 0 0 0",
                     busy, in_ready, res_valid, mac_cntl, mac_a, mac_b, res_data);
        end
        in_valid = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        start = 1; len = 1; a_in = two; b_in = two; in_valid = 1;
        exp_q.push_back({N{16'h4080}});
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            start = 0;
            if (k == 1) begin
                total++;
                if (mac_cntl !== 0 || mac_a !== two) begin
                    bad++;
                    $display("FAIL rejob_beat: cntl=%b a=%h want 0 %h", mac_cntl, mac_a, two);
                end
                in_valid = 0;
            end
            if (k == 4) begin
                total++;
                if (res_valid !== 1 || exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rejob_valid: res_valid=%b want 1", res_valid);
                end else begin
                    e = exp_q.pop_front();
                    total++;
                    if (res_data !== e) begin
                        bad++;
                        $display("FAIL rejob_data: res_data=%h want %h", res_data, e);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t av[2], ev[2], e;
        int   lens[2];
        av[0] = {N{16'h3F80}}; ev[0] = {N{16'h4000}}; lens[0] = 2;
        av[1] = {N{16'h4000}}; ev[1] = {N{16'h4080}}; lens[1] = 1;
        for (int j = 0; j < 2; j++) begin
            int nacc = 0;
            bit pv = 0, pr = 0, done = 0;
            @(negedge clk);
            start = 1; len = LEN_W'(lens[j]); a_in = av[j]; b_in = av[j]; in_valid = 1; res_ready = 1;
            exp_q.push_back(ev[j]);
            for (int i = 0; i < 30 && !done; i++) begin
                @(negedge clk);
                start = 0;
                if (pv && pr) begin
                    total++;
                    if (mac_cntl !== (nacc != 0)) begin
                        bad++;
                        $display("FAIL b2b_job%0d_cntl%0d: mac_cntl=%b want %b", j, nacc, mac_cntl, (nacc != 0));
                    end
                    nacc++;
                end
                if (res_valid === 1'b1 && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    total++;
                    if (res_data !== e) begin
                        bad++;
                        $display("FAIL b2b_job%0d_data: res_data=%h want %h", j, res_data, e);
                    end
                    done = 1;
                end
                pv = in_valid;
                pr = in_ready;
            end
            total++;
            if (!done || nacc != lens[j]) begin
                bad++;
                $display("FAIL b2b_job%0d_done: done=%0d beats=%0d want 1 %0d", j, done, nacc, lens[j]);
            end
        end
        in_valid = 0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_toggle();
        test_hold();
        test_zero_len();
        test_reset_mid();
        test_back_to_back();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left: pending=%0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bf16_mac_sequencer.md
Name: bf16_mac_sequencer

Overview:
Job controller for the N-lane bfloat16 MAC array. It accepts a dot-product job of length len, streams len operand beats into all lanes through a valid/ready handshake, and drives the MAC control so that the first beat loads and later beats accumulate. It then waits out the MAC pipeline latency and presents the N lane results on a valid/ready result port. It sits between the operand source (buffer or DMA) and the MAC array, and is the only driver of the array's a, b and control inputs.

Parameters:
N, 2, number of MAC lanes; each lane is 16 bits wide.
LEN_W, 8, width of the job-length field.
MAC_LAT, 2, MAC array latency: operands presented in cycle t are reflected on mac_out from cycle t+MAC_LAT onward.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  job request; sampled in IDLE only.
len  in  LEN_W  beats per job; sampled with start.
busy  out  1  high in every state except IDLE.
in_valid  in  1  operand beat valid.
in_ready  out  1  high only in FEED.
a_in  in  16*N  operand A; lane i occupies bits [16i+15:16i].
b_in  in  16*N  operand B; same lane packing as a_in.
mac_a  out  16*N  registered operand A to the MAC array.
mac_b  out  16*N  registered operand B to the MAC array.
mac_cntl  out  1  0 = load (out = a*b); 1 = accumulate (out += a*b).
mac_out  in  16*N  lane results from the MAC array.
res_valid  out  1  result available.
res_ready  in  1  result accepted.
res_data  out  16*N  captured lane results.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; busy=0, in_ready=0, res_valid=0; mac_a=0, mac_b=0, mac_cntl=1; res_data=0; beat and drain counters=0. Reset mid-job abandons the job with no result.
- States: IDLE, FEED, DRAIN, HOLD.
- IDLE:
  - start=1 with len!=0: latch len, clear the beat counter, go to FEED.
  - start=1 with len==0: ignored; stays IDLE with no result.
  - start outside IDLE: ignored.
- FEED:
  - in_ready=1.
  - A beat is accepted when in_valid && in_ready at a clock edge. On that edge mac_a<=a_in, mac_b<=b_in. mac_cntl<=0 for the first beat of the job, 1 for every later beat. The beat counter increments.
  - Cycle with no beat accepted (bubble): mac_a<=0, mac_b<=0, mac_cntl<=1, so the accumulator adds +0.
  - Accepted -0 accumulators becoming +0 through this path is acceptable.
  - On acceptance of beat number len: go to DRAIN and load the drain counter with MAC_LAT. in_ready drops in the next cycle.
- DRAIN:
  - mac_a/mac_b are driven to 0 with mac_cntl=1 (bubbles).
  - Each cycle: if drain counter==0, capture res_data<=mac_out, set res_valid<=1 and go to HOLD; otherwise decrement the counter.
  - DRAIN lasts MAC_LAT+1 cycles.
- HOLD:
  - res_valid=1; res_data is stable and bubbles continue on the MAC ports.
  - On res_valid && res_ready: res_valid<=0, go to IDLE.
  - A new start is accepted no earlier than the cycle after the return to IDLE.
- Latency: with in_valid held high, start is sampled at edge 0, beats are accepted at edges 1..len, and res_valid is high from cycle len+MAC_LAT+2.
- The next job's first beat always uses mac_cntl=0, so no explicit clear is needed between jobs.
- The block performs no arithmetic on the data; operands and results pass through unmodified.

Test Plan:
1. N=2, MAC_LAT=2, len=1; a_in={0x4000,0x3F80}, b_in={0x3F80,0x4040}; res_ready=1 -> mac_cntl=0 on the beat; res_data={0x4000,0x4040}; res_valid high exactly in cycle 5.
2. len=4; all lanes a=b=0x3F80 (1.0); in_valid toggles 1,0,1,0,... -> in_ready held in FEED; bubble cycles show mac_a=mac_b=0, mac_cntl=1; every lane of res_data = 0x4080 (4.0).
3. Job done with res_ready=0 for 5 cycles, and start pulsed during HOLD -> res_valid and res_data held stable; busy=1; start ignored; exactly one handshake occurs when res_ready rises.
4. start with len=0 -> busy stays 0; in_ready stays 0; no res_valid ever.
5. rst_n pulled low in FEED after 2 of 4 beats -> all outputs return to reset values immediately. A new job with len=1, a=b=0x4000 then yields 0x4080 (4.0) per lane, with mac_cntl=0 on its beat.
6. Back-to-back jobs: len=2 with all 0x3F80, then len=1 with a=0x4000, b=0x4000 -> first result 0x4000 (2.0); second result 0x4080 (4.0), confirming the load beat clears the accumulator.
